exec_wb_stage: RTL and testbench
================================

EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- instrValid  in  1  an instruction is offered.
- instrReady  out  1  the stage accepts an instruction this cycle.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV-imm, 6 SHL, 7 SHR (logical).
- rd  in  3  destination register.
- rs1  in  3  source A register.
- rs2  in  3  source B register.
- imm  in  16  immediate for MOV-imm.
- rdAddrA  out  3  regfile read address A.
- rdDataA  in  16  regfile read data A, asynchronous read.
- rdAddrB  out  3  regfile read address B.
- rdDataB  in  16  regfile read data B, asynchronous read.
- write  out  1  regfile write enable.
- wrAddr  out  3  regfile write address.
- wrData  out  16  regfile write data.
- busy  out  1  EX or WB stage holds a valid instruction.

Function
REQ-002 rdAddrA SHALL equal rs1 and rdAddrB SHALL equal rs2, combinationally, every cycle.
REQ-003 An instruction SHALL be accepted at a posedge where instrValid=1 and instrReady=1; accepted op, rd, imm and operands A/B SHALL load into the EX register and set exValid.
REQ-004 Operand selection at accept SHALL use this priority per source: EX result if exValid, EX done and exRd matches; else wbData if wbValid and wbRd matches; else rdDataA/rdDataB.
REQ-005 The pipeline SHALL have three stages: accept, EX, WB. write SHALL equal wbValid; wrAddr=wbRd; wrData=wbData.
REQ-006 Latency for single-cycle ops: accept at edge T -> EX valid in cycle T+1 -> write=1 in cycle T+2.
REQ-007 All arithmetic SHALL be 16-bit modulo 2^16 with no carry or borrow output: SUB = A-B; MOV-imm result = imm, operands ignored.
REQ-008 The EX FSM SHALL have states IDLE (no EX instruction), EXEC (single-cycle op or shift with count=0) and SHIFT (count!=0).
REQ-009 On accept of SHL/SHR, the FSM SHALL load acc=A and count=B[3:0]; B[15:4] SHALL be ignored.
REQ-010 In SHIFT, each cycle SHALL shift acc by one bit, zero-filled, and decrement count; the FSM SHALL go to EXEC when count reaches 0.
REQ-011 A shift by n SHALL occupy EX for n+1 cycles; n=0 SHALL behave as a single-cycle op returning A.
REQ-012 From EXEC, the result SHALL move to WB at the next edge; the FSM SHALL go to EXEC if a new instruction is accepted that edge, else IDLE.
REQ-013 instrReady SHALL be 0 exactly when the FSM is in SHIFT; otherwise it SHALL be 1.
REQ-014 While EX stalls in SHIFT, WB SHALL receive a bubble, with wbValid=0 on the following cycle.
REQ-015 WB SHALL always drain in one cycle; the regfile commits at the edge ending the write cycle.
REQ-016 Multiple in-flight writes to the same rd SHALL resolve youngest-first through the REQ-004 priority.
REQ-017 busy SHALL equal exValid OR wbValid.

Reset
REQ-018 reset=1 SHALL immediately clear exValid, wbValid, count and the FSM to IDLE, forcing write=0, busy=0 and instrReady=1 without waiting for clk.
REQ-019 wrAddr and wrData SHALL reset to 0.
REQ-020 An instruction in flight when reset asserts SHALL never be written back.
REQ-021 Regfile contents are not owned by this block and SHALL NOT be cleared by it.

Verification
REQ-022 Reset: assert reset mid-cycle -> write=0, busy=0, instrReady=1 before the next edge.
REQ-023 MOV-imm: MOV r3,0x1234 accepted at edge T -> in cycle T+2 write=1, wrAddr=3, wrData=0x1234; write=0 in cycle T+3.
REQ-024 Forwarding: MOV r1,5 then ADD r2=r1+r1 next cycle -> wrData=0x000A via EX forward; then SUB r3=r1-r2 -> wrData=0xFFFB via WB/EX forward.
REQ-025 Wrap: with r0=0 and r1=1, SUB r5=r0-r1 -> wrData=0xFFFF.
REQ-026 Shift: with r1=0x8001 and r2=3, SHL r4=r1<<r2 -> instrReady=0 for 3 cycles, then wrData=0x0008; SHR with amount 0 -> single-cycle, result=A.
REQ-027 Reset mid-shift: assert reset in SHIFT with count=2 -> write stays 0 after release and r4 is never written.

Source files
------------

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: 16-bit ALU plus iterative shifter, with EX/WB operand forwarding.
// Single-cycle ops write back 2 cycles after accept; a shift by n adds n cycles and holds instrReady low meanwhile.
module exec_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        instrValid,
    output logic        instrReady,
    input  logic [2:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs1,
    input  logic [2:0]  rs2,
    input  logic [15:0] imm,
    output logic [2:0]  rdAddrA,
    input  logic [15:0] rdDataA,
    output logic [2:0]  rdAddrB,
    input  logic [15:0] rdDataB,
    output logic        write,
    output logic [2:0]  wrAddr,
    output logic [15:0] wrData,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_MOV = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  ex_op_q, ex_op_d, ex_rd_q, ex_rd_d;
    logic [15:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  count_q, count_d;
    logic        wb_valid_q, wb_valid_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic [15:0] wb_data_q, wb_data_d;

    logic        ex_valid, ex_done, accept, in_shift;
    logic [15:0] opa, opb, ex_result;

    assign rdAddrA    = rs1;
    assign rdAddrB    = rs2;
    assign ex_valid   = (state_q != IDLE);
    assign ex_done    = (state_q == EXEC);
    assign instrReady = (state_q != SHIFT);
    assign accept     = instrValid && instrReady;
    assign in_shift   = (op == OP_SHL) || (op == OP_SHR);
    assign write      = wb_valid_q;
    assign wrAddr     = wb_rd_q;
    assign wrData     = wb_data_q;
    assign busy       = ex_valid || wb_valid_q;

    // Youngest producer wins: finished EX result, then the WB slot, then the regfile.
    always_comb begin
        opa = rdDataA;
        if (ex_done && ex_rd_q == rs1)         opa = ex_result;
        else if (wb_valid_q && wb_rd_q == rs1) opa = wb_data_q;
        opb = rdDataB;
        if (ex_done && ex_rd_q == rs2)         opb = ex_result;
        else if (wb_valid_q && wb_rd_q == rs2) opb = wb_data_q;
    end

    always_comb begin
        case (ex_op_q)
            OP_ADD:  ex_result = ex_a_q + ex_b_q;
            OP_SUB:  ex_result = ex_a_q - ex_b_q;
            OP_AND:  ex_result = ex_a_q & ex_b_q;
            OP_OR:   ex_result = ex_a_q | ex_b_q;
            OP_XOR:  ex_result = ex_a_q ^ ex_b_q;
            OP_MOV:  ex_result = ex_imm_q;
            default: ex_result = acc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ex_op_d    = ex_op_q;
        ex_rd_d    = ex_rd_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        acc_d      = acc_q;
        count_d    = count_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            SHIFT: begin
                acc_d   = (ex_op_q == OP_SHL) ? (acc_q << 1) : (acc_q >> 1);
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = EXEC;
            end
            EXEC: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ex_rd_q;
                wb_data_d  = ex_result;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Never taken in SHIFT, so it cannot collide with the shift update above.
        if (accept) begin
            ex_op_d  = op;
            ex_rd_d  = rd;
            ex_a_d   = opa;
            ex_b_d   = opb;
            ex_imm_d = imm;
            acc_d    = opa;
            count_d  = in_shift ? opb[3:0] : 4'd0;
            state_d  = (in_shift && opb[3:0] != 4'd0) ? SHIFT : EXEC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ex_op_q    <= 3'd0;
            ex_rd_q    <= 3'd0;
            ex_a_q     <= 16'd0;
            ex_b_q     <= 16'd0;
            ex_imm_q   <= 16'd0;
            acc_q      <= 16'd0;
            count_q    <= 4'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 3'd0;
            wb_data_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            ex_op_q    <= ex_op_d;
            ex_rd_q    <= ex_rd_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: directed scenarios plus random instruction streams against an
// architectural (in-order, one-instruction-at-a-time) model with expected writeback cycles.
module tb_exec_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        instrValid, instrReady;
    logic [2:0]  op, rd, rs1, rs2;
    logic [15:0] imm;
    logic [2:0]  rdAddrA, rdAddrB;
    logic [15:0] rdDataA, rdDataB;
    logic        write, busy;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;

    exec_wb_stage dut (
        .clk(clk), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .write(write), .wrAddr(wrAddr), .wrData(wrData), .busy(busy)
    );

    always #5 clk = ~clk;

    // Regfile owned by the bench: asynchronous read, commit at the edge ending a write cycle.
    logic [15:0] rf [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                            16'h4444, 16'h5555, 16'h6666, 16'h7777};
    assign rdDataA = rf[rdAddrA];
    assign rdDataB = rf[rdAddrB];
    always @(posedge clk) if (write) rf[wrAddr] <= wrData;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] dat;
        int          start;
        int          wcyc;
        int          stall_end;
    } pend_t;

    pend_t       pq[$];
    logic [15:0] arch [8];
    int          checks = 0;
    int          failures = 0;
    logic        obs_write, obs_ready;
    int          ready_lows;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a,
                                               input logic [15:0] b, input logic [15:0] im);
        int ia, ib, n;
        ia = a;
        ib = b;
        n  = ib % 16;
        case (o)
            3'd0:    return 16'((ia + ib) % 65536);
            3'd1:    return 16'((ia - ib + 65536) % 65536);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return im;
            3'd6:    return 16'((ia * (1 << n)) % 65536);
            default: return 16'(ia / (1 << n));
        endcase
    endfunction

    task automatic step(input logic v, input logic [2:0] o, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2, input logic [15:0] im);
        logic        exp_w, exp_b, exp_r;
        logic [15:0] res;
        int          n;
        pend_t       p;
        @(negedge clk);
        exp_w = (pq.size() > 0) && (pq[0].wcyc == cyc);
        exp_b = 1'b0;
        exp_r = 1'b1;
        foreach (pq[i]) begin
            if (pq[i].start <= cyc && cyc <= pq[i].wcyc)      exp_b = 1'b1;
            if (pq[i].start <= cyc && cyc <= pq[i].stall_end) exp_r = 1'b0;
        end
        obs_write = write;
        obs_ready = instrReady;
        chk("write", write, exp_w);
        chk("busy", busy, exp_b);
        chk("instr_ready", instrReady, exp_r);
        if (exp_w) begin
            if (write) begin
                chk("wr_addr", wrAddr, pq[0].rd);
                chk("wr_data", wrData, pq[0].dat);
            end
            void'(pq.pop_front());
        end
        instrValid = v; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        #1;
        chk("rd_addr_a", rdAddrA, s1);
        chk("rd_addr_b", rdAddrB, s2);
        if (v && exp_r) begin
            n   = (o == 3'd6 || o == 3'd7) ? int'(arch[s2] % 16) : 0;
            res = ref_result(o, arch[s1], arch[s2], im);
            p.rd = d; p.dat = res; p.start = cyc + 1; p.wcyc = cyc + 2 + n; p.stall_end = cyc + n;
            pq.push_back(p);
            arch[d] = res;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        instrValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_write", write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", instrReady, 1'b1);
        chk("rst_wr_addr", wrAddr, 3'd0);
        chk("rst_wr_data", wrData, 16'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pq.delete();
        foreach (arch[i]) arch[i] = rf[i];
    endtask

    initial begin
        reset = 1'b1; instrValid = 1'b0; op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0; imm = 16'h0;
        #1;
        chk("init_write", write, 1'b0);
        chk("init_busy", busy, 1'b0);
        chk("init_ready", instrReady, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        foreach (arch[i]) arch[i] = rf[i];

        // MOV r3,0x1234: write in the second cycle after the accept cycle, gone the cycle after.
        step(1'b1, 3'd5, 3'd3, 3'd0, 3'd0, 16'h1234);
        idle(1);
        step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
        chk("mov_write", obs_write, 1'b1);
        chk("mov_wr_addr", wrAddr, 3'd3);
        chk("mov_wr_data", wrData, 16'h1234);
        step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
        chk("mov_write_after", obs_write, 1'b0);

        // Back-to-back dependent ops through EX and WB forwarding.
        step(1'b1, 3'd5, 3'd1, 3'd0, 3'd0, 16'd5);
        step(1'b1, 3'd0, 3'd2, 3'd1, 3'd1, 16'h0);
        step(1'b1, 3'd1, 3'd3, 3'd1, 3'd2, 16'h0);
        idle(4);
        chk("fwd_add_r2", rf[2], 16'h000A);
        chk("fwd_sub_r3", rf[3], 16'hFFFB);

        step(1'b1, 3'd5, 3'd0, 3'd0, 3'd0, 16'd0);
        step(1'b1, 3'd5, 3'd1, 3'd0, 3'd0, 16'd1);
        step(1'b1, 3'd1, 3'd5, 3'd0, 3'd1, 16'h0);
        idle(4);
        chk("wrap_sub_r5", rf[5], 16'hFFFF);

        // SHL by 3 stalls for exactly three cycles.
        step(1'b1, 3'd5, 3'd1, 3'd0, 3'd0, 16'h8001);
        step(1'b1, 3'd5, 3'd2, 3'd0, 3'd0, 16'd3);
        step(1'b1, 3'd6, 3'd4, 3'd1, 3'd2, 16'h0);
        ready_lows = 0;
        repeat (6) begin
            step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
            if (!obs_ready) ready_lows++;
        end
        chk("shl_stall_cycles", ready_lows, 3);
        chk("shl_r4", rf[4], 16'h0008);

        step(1'b1, 3'd5, 3'd6, 3'd0, 3'd0, 16'd0);
        step(1'b1, 3'd7, 3'd7, 3'd1, 3'd6, 16'h0);
        step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
        chk("shr0_no_stall", obs_ready, 1'b1);
        idle(3);
        chk("shr0_r7", rf[7], 16'h8001);

        // Reset while the shifter has count=2 left: r4 keeps its old value.
        step(1'b1, 3'd5, 3'd4, 3'd0, 3'd0, 16'h5A5A);
        idle(3);
        step(1'b1, 3'd6, 3'd4, 3'd1, 3'd2, 16'h0);
        step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
        do_reset();
        idle(8);
        chk("rst_shift_r4", rf[4], 16'h5A5A);

        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 16'($urandom));
        end
        idle(24);
        chk("drained", pq.size(), 0);
        foreach (rf[i]) chk("final_rf", rf[i], arch[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
